// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between fetch/MEM requesters, the arbiter and the memory
//
// Signal groups:
//   fetch  : if_req, if_addr -> if_rdata, if_ready
//   data   : d_read, d_write, d_addr, d_wdata -> d_rdata, d_ready
//   memory : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack
//   status : stall_o, err_o
// master modport is the arbiter's view; slave modport is the surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;

  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          stall_o;
  logic          err_o;

  modport master (
    input  if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_o, err_o
  );

  modport slave (
    output if_req, if_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between IF fetch and MEM-stage load/store
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : mem_port_arbiter_if.master (fetch, data, memory handshake, stall_o, err_o)
// Parameter:
//   TIMEOUT : max cycles mem_req may stay high without mem_ack (>= 2)
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_VAL = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t        state_q;
  state_t        state_d;
  logic          last_d_q;
  logic [WW-1:0] wd_q;
  logic          grant_d;
  logic          grant_i;
  logic          done;
  logic          timeout;
  logic          d_pend;

  assign d_pend = bus.d_read | bus.d_write;

  // Combinational so the pipeline freezes in the same cycle a request appears.
  assign bus.stall_o = (bus.if_req & ~bus.if_ready) | (d_pend & ~bus.d_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time gets the port.
        if (d_pend && (!bus.if_req || !last_d_q)) begin
          grant_d = 1'b1;
          state_d = BUSY_D;
        end else if (bus.if_req) begin
          grant_i = 1'b1;
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          done = 1'b1;
        end else if (wd_q == TO_VAL) begin
          done    = 1'b1;
          timeout = 1'b1;
        end
        if (done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.if_ready  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_ready   <= 1'b0;
      bus.err_o     <= 1'b0;
      wd_q          <= '0;
      last_d_q      <= 1'b0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
      // Simultaneous load and store is a controller bug; it is flagged and run as a store.
      if (bus.d_read && bus.d_write) begin
        bus.err_o <= 1'b1;
      end
      if (grant_d) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.d_write;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        wd_q          <= WW'(1);
        last_d_q      <= 1'b1;
      end else if (grant_i) begin
        bus.mem_req  <= 1'b1;
        bus.mem_we   <= 1'b0;
        bus.mem_addr <= bus.if_addr;
        wd_q         <= WW'(1);
        last_d_q     <= 1'b0;
      end else if (done) begin
        // A timed-out access completes with zero data so the requester never hangs.
        bus.mem_req <= 1'b0;
        if (timeout) begin
          bus.err_o <= 1'b1;
        end
        if (state_q == BUSY_I) begin
          bus.if_ready <= 1'b1;
          bus.if_rdata <= timeout ? '0 : bus.mem_rdata;
        end else begin
          bus.d_ready <= 1'b1;
          if (!bus.mem_we) begin
            bus.d_rdata <= timeout ? '0 : bus.mem_rdata;
          end
        end
      end else if (state_q == BUSY_I || state_q == BUSY_D) begin
        wd_q <= wd_q + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester/memory model state
  bit          if_pend, d_pend, d_rd, d_wr, last_d, exp_err;
  logic [31:0] if_a, d_a, d_wd, exp_if_rdata, exp_d_rdata;
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic set_inputs();
    bus.if_req  = if_pend;
    bus.if_addr = if_a;
    bus.d_read  = d_pend & d_rd;
    bus.d_write = d_pend & d_wr;
    bus.d_addr  = d_a;
    bus.d_wdata = d_wd;
    if (d_pend && d_rd && d_wr) exp_err = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_pend = 0; d_pend = 0; d_rd = 0; d_wr = 0;
    if_a = '0; d_a = '0; d_wd = '0;
    set_inputs();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_if_ready", bus.if_ready, 0);
    check("rst_d_ready", bus.d_ready, 0);
    check("rst_err", bus.err_o, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_stall", bus.stall_o, 0);
    rst = 1'b0;
    last_d = 0; exp_err = 0; exp_if_rdata = '0; exp_d_rdata = '0;
  endtask

  // Caller is at a negedge with the arbiter idle and requests already applied.
  // lat = mem_req cycle in which mem_ack arrives; 0 means never (timeout).
  task automatic txn(input int lat, output int gcyc);
    bit g_d, we, to, late;
    logic [31:0] a, rv;
    int c;
    g_d = d_pend && (!if_pend || !last_d);
    last_d = g_d;
    a  = g_d ? d_a : if_a;
    we = g_d && d_wr;
    to = (lat == 0);
    rv = '0;
    @(negedge clk);
    gcyc = cyc;
    check("grant_req", bus.mem_req, 1);
    check("grant_addr", bus.mem_addr, a);
    check("grant_we", bus.mem_we, we);
    if (we) check("grant_wdata", bus.mem_wdata, d_wd);
    check("busy_stall", bus.stall_o, 1);
    check("busy_err", bus.err_o, exp_err);
    c = 1;
    while (1) begin
      if (!to && c == lat) begin
        rv = we ? $urandom : mem_rd(a);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rv;
      end else begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = $urandom;
      end
      @(negedge clk);
      if ((!to && c == lat) || (to && c == TIMEOUT)) break;
      c++;
      check("req_held", bus.mem_req, 1);
      check("addr_stable", bus.mem_addr, a);
      if (c > TIMEOUT + 2) begin
        check("req_bound", bus.mem_req, 0);
        break;
      end
    end
    if (to) exp_err = 1'b1;
    if (g_d) begin
      if (we) begin
        if (!to) mem[a] = d_wd;
      end else begin
        exp_d_rdata = to ? 32'h0 : rv;
      end
    end else begin
      exp_if_rdata = to ? 32'h0 : rv;
    end
    check("resp_req_low", bus.mem_req, 0);
    check("resp_if_ready", bus.if_ready, !g_d);
    check("resp_d_ready", bus.d_ready, g_d);
    check("resp_if_rdata", bus.if_rdata, exp_if_rdata);
    check("resp_d_rdata", bus.d_rdata, exp_d_rdata);
    check("resp_err", bus.err_o, exp_err);
    check("resp_stall", bus.stall_o, g_d ? if_pend : d_pend);
    if (g_d) d_pend = 0; else if_pend = 0;
    set_inputs();
    // A stray ack after the access has finished must have no effect.
    late = to && ($urandom_range(0, 1) == 1);
    bus.mem_ack = late;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("idle_no_grant", bus.mem_req, 0);
    check("idle_if_ready", bus.if_ready, 0);
    check("idle_d_ready", bus.d_ready, 0);
  endtask

  task automatic new_requests();
    int k;
    if (!if_pend && $urandom_range(0, 2) != 0) begin
      if_pend = 1;
      if_a = 32'($urandom_range(0, 15)) << 2;
    end
    if ((!d_pend && $urandom_range(0, 2) != 0) || (!d_pend && !if_pend)) begin
      d_pend = 1;
      k = $urandom_range(0, 7);
      d_rd = (k != 1 && k != 2 && k != 3);
      d_wr = (k <= 3);
      d_a  = 32'($urandom_range(0, 15)) << 2;
      d_wd = $urandom;
    end
    set_inputs();
    #1;
    check("idle_stall", bus.stall_o, if_pend | d_pend);
  endtask

  task automatic reset_mid();
    int g;
    d_pend = 1; d_rd = 1; d_wr = 1; d_a = 32'h80; d_wd = $urandom;
    if_pend = 0;
    set_inputs();
    @(negedge clk);
    check("t6_busy", bus.mem_req, 1);
    check("t6_err_before", bus.err_o, 1);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_req_low", bus.mem_req, 0);
    check("t6_no_ready", bus.d_ready, 0);
    check("t6_err_clear", bus.err_o, 0);
    rst = 1'b0;
    d_pend = 0;
    set_inputs();
    exp_err = 0; last_d = 0; exp_if_rdata = '0; exp_d_rdata = '0;
    @(negedge clk);
    check("t6_idle", bus.mem_req, 0);
    check("t6_d_ready", bus.d_ready, 0);
    // Arbiter must accept a fresh request right after the abandoned one.
    if_pend = 1; if_a = 32'h3C;
    set_inputs();
    txn(1, g);
  endtask

  initial begin
    int g0, g1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    do_reset();

    // T1 fetch with ack on the third mem_req cycle
    mem[32'h40] = 32'h2008000A;
    if_pend = 1; if_a = 32'h40;
    set_inputs();
    #1 check("t1_stall", bus.stall_o, 1);
    txn(3, g0);
    check("t1_if_rdata", exp_if_rdata, 32'h2008000A);

    // T2 simultaneous requests after reset: data wins, then fetch
    do_reset();
    if_pend = 1; if_a = 32'h44;
    d_pend = 1; d_rd = 1; d_wr = 0; d_a = 32'h100; d_wd = '0;
    set_inputs();
    txn(1, g0);
    check("t2_fetch_pending", if_pend, 1);
    txn(2, g1);

    // T3 store then load back
    d_pend = 1; d_rd = 0; d_wr = 1; d_a = 32'h200; d_wd = 32'hDEADBEEF;
    set_inputs();
    txn(2, g0);
    d_pend = 1; d_rd = 1; d_wr = 0; d_a = 32'h200;
    set_inputs();
    txn(1, g0);
    check("t3_readback", bus.d_rdata, 32'hDEADBEEF);

    // T4 fairness: both always pending, ack in one cycle, 3-cycle round trips
    do_reset();
    g1 = -1;
    for (int i = 0; i < 6; i++) begin
      if (!if_pend) begin if_pend = 1; if_a = 32'($urandom_range(0, 15)) << 2; end
      if (!d_pend) begin d_pend = 1; d_rd = 1; d_wr = 0; d_a = 32'($urandom_range(0, 15)) << 2; end
      set_inputs();
      txn(1, g0);
      check("t4_alternate", {31'b0, last_d}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (g1 >= 0) check("t4_round_trip", g0 - g1, 3);
      g1 = g0;
    end

    // T5 timeout on a fetch
    if_pend = 1; if_a = 32'h10; d_pend = 0;
    set_inputs();
    txn(0, g0);
    check("t5_err_sticky", bus.err_o, 1);

    // T6 reset in the second BUSY_D cycle
    reset_mid();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if (i % 50 == 49) begin
        reset_mid();
      end
      new_requests();
      txn(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4), g0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
